muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: request to begin the operation selected by control.
REQ-004 SHALL have port control, input, 4 bits: ALU control code; 4'b1000 = mult, 4'b1001 = multu, 4'b1010 = div, 4'b1011 = divu.
REQ-005 SHALL have ports a and b, input, 32 bits each: rs and rt operands.
REQ-006 SHALL have ports wr_hi and wr_lo, input, 1 bit each: mthi/mtlo write strobes.
REQ-007 SHALL have port wdata, input, 32 bits: data for wr_hi/wr_lo.
REQ-008 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have ports hi and lo, output, 32 bits each: HI/LO registers, always readable.

Function
REQ-011 SHALL implement an FSM with states IDLE, RUN and FIX, plus a 5-bit iteration counter.
REQ-012 In IDLE, a rising edge with start=1 and a valid code SHALL latch a, b and control, clear the counter, and enter RUN.
REQ-013 In IDLE, start=1 with any other code SHALL be ignored: no state change, no done pulse.
REQ-014 start while busy=1 SHALL be ignored.
REQ-015 RUN SHALL perform one radix-2 iteration per cycle for exactly 32 cycles (counter 0..31), then enter FIX.
REQ-016 Multiply SHALL be shift-add; divide SHALL be restoring. Signed codes SHALL operate on magnitudes and sign-correct in FIX.
REQ-017 FIX SHALL write the results to hi/lo, pulse done for exactly one cycle, and return to IDLE.
REQ-018 Latency: start accepted at edge T; hi/lo update and done rises at edge T+33; done falls at edge T+34; the next start can be accepted at edge T+34.
REQ-019 busy SHALL be high from edge T through edge T+33, i.e. in the RUN and FIX states.
REQ-020 Multiply results: hi = product[63:32], lo = product[31:0]. mult uses two's-complement operands; multu uses unsigned operands.
REQ-021 Divide results: lo = quotient, hi = remainder. Signed divide truncates toward zero; the remainder takes the sign of the dividend.
REQ-022 Divide by zero SHALL give lo = 32'hFFFFFFFF and hi = a, for both signed and unsigned divide.
REQ-023 Signed divide of 32'h80000000 by 32'hFFFFFFFF SHALL give lo = 32'h80000000, hi = 0.
REQ-024 In IDLE, wr_hi/wr_lo SHALL load wdata into hi/lo at the clock edge; both strobes together load both registers.
REQ-025 wr_hi/wr_lo SHALL be ignored while busy=1.
REQ-026 A write in the same cycle as an accepted start SHALL take effect; the operation's result later overwrites hi and lo.
REQ-027 hi and lo SHALL hold their values in all other cycles.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, counter 0, busy=0, done=0, hi=0, lo=0, and clear all internal operand and accumulator registers.
REQ-029 Reset during RUN or FIX SHALL abort the operation with no done pulse and no partial result visible.
REQ-030 The first start SHALL be accepted at the first rising edge after rst deasserts.

Configuration
REQ-031 Macro MULDIV_DIV_EN SHALL control divide support.
REQ-032 With MULDIV_DIV_EN defined, div/divu SHALL be accepted and implemented as specified above.
REQ-033 Without MULDIV_DIV_EN, codes 4'b1010 and 4'b1011 SHALL be treated as invalid (REQ-013), no divide datapath SHALL be synthesized, and multiply timing SHALL be unchanged.

Verification
REQ-034 mult, a=32'hFFFFFFFE (-2), b=32'h00000003 -> at edge T+33: hi=32'hFFFFFFFF, lo=32'hFFFFFFFA, done high for one cycle, busy low at T+34.
REQ-035 multu, a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001; second start asserted at T+5 is ignored.
REQ-036 div, a=32'hFFFFFFF9 (-7), b=32'h00000002 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1); divu with b=0, a=32'h12345678 -> lo=32'hFFFFFFFF, hi=32'h12345678.
REQ-037 wr_hi with wdata=32'hA5A5A5A5 in IDLE -> hi=32'hA5A5A5A5; wr_lo at T+10 of a mult -> lo unaffected until result.
REQ-038 rst pulse at T+15 of a mult -> hi=lo=0, busy=0, no done pulse; a new mult started after reset completes with correct result.
REQ-039 Build without MULDIV_DIV_EN: start with control=4'b1010 -> busy stays 0, done never asserts, hi/lo unchanged.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers (MIPS mult/multu/div/divu, mthi/mtlo).
// Define MULDIV_DIV_EN to build the restoring divider; without it only mult/multu are accepted.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  control,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [63:0] r_acc;
    logic [31:0] r_mcand;
    logic        r_neg_q;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_valid;
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [63:0] w_step;
    logic [63:0] w_prod;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_signed = ~control[0];
    assign w_a_neg  = w_signed & a[31];
    assign w_b_neg  = w_signed & b[31];
    assign w_a_mag  = w_a_neg ? (32'd0 - a) : a;
    assign w_b_mag  = w_b_neg ? (32'd0 - b) : b;

    // Shift-add: low half holds the multiplier, consumed LSB first as the product shifts in.
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mcand} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};
    assign w_prod     = r_neg_q ? (64'd0 - r_acc) : r_acc;

`ifdef MULDIV_DIV_EN
    logic        r_is_div;
    logic        r_neg_r;
    logic        r_bzero;
    logic        w_is_div;
    logic [32:0] w_rem_sh;
    logic        w_ge;
    logic [31:0] w_diff;
    logic [63:0] w_div_next;

    assign w_valid  = (control[3:2] == 2'b10);
    assign w_is_div = control[1];

    // Restoring divide: {remainder, quotient} shift left; the quotient bit enters at the bottom.
    assign w_rem_sh   = {r_acc[63:32], r_acc[31]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_mcand});
    assign w_diff     = w_rem_sh[31:0] - r_mcand;
    assign w_div_next = {(w_ge ? w_diff : w_rem_sh[31:0]), r_acc[30:0], w_ge};
    assign w_step     = r_is_div ? w_div_next : w_mul_next;

    always_comb begin
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        if (r_is_div) begin
            w_res_hi = r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
            w_res_lo = r_bzero ? 32'hFFFF_FFFF
                     : (r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_div <= 1'b0;
            r_neg_r  <= 1'b0;
            r_bzero  <= 1'b0;
        end else if (r_state == S_IDLE && start && w_valid) begin
            r_is_div <= w_is_div;
            r_neg_r  <= w_a_neg;
            r_bzero  <= (b == 32'd0);
        end
    end
`else
    assign w_valid  = (control[3:1] == 3'b100);
    assign w_step   = w_mul_next;
    assign w_res_hi = w_prod[63:32];
    assign w_res_lo = w_prod[31:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_acc   <= 64'd0;
            r_mcand <= 32'd0;
            r_neg_q <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wr_hi) r_hi <= wdata;
                    if (wr_lo) r_lo <= wdata;
                    // Both operations load magnitude of a low and the other operand aside.
                    if (start && w_valid) begin
                        r_state <= S_RUN;
                        r_cnt   <= 5'd0;
                        r_acc   <= {32'd0, w_a_mag};
                        r_mcand <= w_b_mag;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                    end
                end
                S_RUN: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table plus hand sequences for restart, mthi/mtlo and reset abort.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  control;
    logic [31:0] a;
    logic [31:0] b;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    res_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   n_done = 0;

    muldiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .control(control),
        .a(a), .b(b), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) n_done++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic res_t model(input logic [3:0] c, input logic [31:0] av, input logic [31:0] bv);
        res_t        r;
        longint      sa, sb, q, rm;
        logic [63:0] p;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        r.hi = 32'd0;
        r.lo = 32'd0;
        case (c)
            4'b1000: begin p = sa * sb; r.hi = p[63:32]; r.lo = p[31:0]; end
            4'b1001: begin p = {32'd0, av} * {32'd0, bv}; r.hi = p[63:32]; r.lo = p[31:0]; end
            4'b1010: begin
                if (bv == 32'd0) begin r.hi = av; r.lo = 32'hFFFF_FFFF; end
                else begin q = sa / sb; rm = sa % sb; r.hi = rm[31:0]; r.lo = q[31:0]; end
            end
            4'b1011: begin
                if (bv == 32'd0) begin r.hi = av; r.lo = 32'hFFFF_FFFF; end
                else begin r.hi = av % bv; r.lo = av / bv; end
            end
            default: ;
        endcase
        return r;
    endfunction

    // mode: 0 plain, 1 second start at T+5, 2 wr_lo at T+10, 3 wr_hi with the start
    task automatic run_op(input logic [3:0] c, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] eh, input logic [31:0] el, input int mode);
        res_t        r;
        res_t        got;
        logic [31:0] hi0, lo0;
        logic        early;
        int          nd0;
        r.hi = eh;
        r.lo = el;
        control = c; a = av; b = bv; start = 1'b1;
        if (mode == 3) begin wr_hi = 1'b1; wdata = 32'h0BAD_F00D; end
        sbq.push_back(r);
        tick();
        start = 1'b0; wr_hi = 1'b0; control = 4'b0000; a = 32'h5555_5555; b = 32'hAAAA_AAAA;
        check("busy_after_start", busy, 1);
        if (mode == 3) check("wr_hi_with_start", hi, 32'h0BAD_F00D);
        hi0 = hi;
        lo0 = lo;
        early = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            if (mode == 1 && k == 5) begin start = 1'b1; control = 4'b1000; a = 32'd7; b = 32'd9; end
            if (mode == 2 && k == 10) begin wr_lo = 1'b1; wdata = 32'hDEAD_BEEF; end
            tick();
            start = 1'b0; wr_lo = 1'b0;
            if (done !== 1'b0) early = 1'b1;
        end
        check("no_early_done", early, 0);
        check("busy_at_T32", busy, 1);
        check("hilo_held_while_busy", {hi, lo}, {hi0, lo0});
        tick();
        check("done_at_T33", done, 1);
        got = sbq.pop_front();
        check("result_hi", hi, got.hi);
        check("result_lo", lo, got.lo);
        tick();
        check("done_low_at_T34", done, 0);
        check("busy_low_at_T34", busy, 0);
        if (mode == 1) begin
            nd0 = n_done;
            repeat (40) tick();
            check("restart_ignored_no_done", n_done, nd0);
            check("restart_ignored_hi", hi, got.hi);
        end
    endtask

    task automatic run_ignored(input logic [3:0] c, input logic [31:0] av, input logic [31:0] bv);
        logic [31:0] hi0, lo0;
        int          nd0;
        logic        saw_busy;
        hi0 = hi; lo0 = lo; nd0 = n_done;
        control = c; a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        saw_busy = 1'b0;
        repeat (36) begin
            if (busy !== 1'b0) saw_busy = 1'b1;
            tick();
        end
        check("ignored_busy", saw_busy, 0);
        check("ignored_no_done", n_done, nd0);
        check("ignored_hilo", {hi, lo}, {hi0, lo0});
    endtask

    vec_t vt[12];
    res_t m;
    logic [3:0]  rc;
    logic [31:0] ra, rb;
    logic        div_en;

    initial begin
`ifdef MULDIV_DIV_EN
        div_en = 1'b1;
`else
        div_en = 1'b0;
`endif
        vt[0]  = '{4'b1000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vt[1]  = '{4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vt[2]  = '{4'b1010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vt[3]  = '{4'b1011, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
        vt[4]  = '{4'b1010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vt[5]  = '{4'b1010, 32'hFFFF_FF00, 32'h0000_0000, 32'hFFFF_FF00, 32'hFFFF_FFFF};
        vt[6]  = '{4'b1000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vt[7]  = '{4'b1010, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2};
        vt[8]  = '{4'b1011, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
        vt[9]  = '{4'b1010, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000};
        m = model(4'b1000, 32'h7FFF_FFFF, 32'h8000_0000);
        vt[10] = '{4'b1000, 32'h7FFF_FFFF, 32'h8000_0000, m.hi, m.lo};
        m = model(4'b1001, 32'h1234_5678, 32'h9ABC_DEF0);
        vt[11] = '{4'b1001, 32'h1234_5678, 32'h9ABC_DEF0, m.hi, m.lo};

        rst = 1'b1; start = 1'b0; control = 4'b0; a = '0; b = '0;
        wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
        tick(); tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;

        // First start right after reset release must be accepted.
        for (int i = 0; i < 12; i++) begin
            if (vt[i].c[1] && !div_en) run_ignored(vt[i].c, vt[i].a, vt[i].b);
            else run_op(vt[i].c, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, 0);
        end

        for (int i = 0; i < 6; i++) begin
            rc = 4'b1000 | 4'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : $urandom;
            m  = model(rc, ra, rb);
            if (rc[1] && !div_en) run_ignored(rc, ra, rb);
            else run_op(rc, ra, rb, m.hi, m.lo, 0);
        end

        run_op(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1);

        wdata = 32'hA5A5_A5A5; wr_hi = 1'b1;
        tick();
        wr_hi = 1'b0;
        check("mthi_idle", hi, 32'hA5A5_A5A5);
        check("mthi_keeps_lo", lo, 32'h0000_0001);
        wdata = 32'h1357_9BDF; wr_hi = 1'b1; wr_lo = 1'b1;
        tick();
        wr_hi = 1'b0; wr_lo = 1'b0;
        check("mthi_mtlo_both", {hi, lo}, {32'h1357_9BDF, 32'h1357_9BDF});

        run_op(4'b1000, 32'h0000_0123, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'hFFFE_DD00, 2);
        run_op(4'b1001, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 3);

        run_ignored(4'b0000, 32'd3, 32'd4);
        run_ignored(4'b1100, 32'd3, 32'd4);

        // Reset in the middle of a multiply: abort, clear, no done.
        control = 4'b1000; a = 32'd1000; b = 32'd1000; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        #2 rst = 1'b1;
        #1;
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        begin
            int nd0;
            nd0 = n_done;
            tick();
            rst = 1'b0;
            repeat (40) tick();
            check("abort_no_done", n_done, nd0);
            check("abort_busy_after", busy, 0);
        end
        run_op(4'b1000, 32'hFFFF_FFF6, 32'h0000_0064, 32'hFFFF_FFFF, 32'hFFFF_FC18, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
